// File: rtl/d_grf_if.sv
// d_grf_if: W-stage write-back bundle plus the two D-stage read ports of the
// general register file. The master side (pipeline) drives the W fields and
// read addresses; the slave side (register file) returns read data and the
// decoded write port.
interface d_grf_if;
  logic [31:0] WIns;
  logic [31:0] WPC;
  logic [31:0] WALU;
  logic [31:0] WDM;
  logic        WRegWrite;
  logic [1:0]  WRegDst;
  logic [1:0]  WRegDataSrc;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  WA;
  logic [31:0] WD;

  modport master (
    output WIns, WPC, WALU, WDM, WRegWrite, WRegDst, WRegDataSrc, A1, A2,
    input  RD1, RD2, WA, WD
  );

  modport slave (
    input  WIns, WPC, WALU, WDM, WRegWrite, WRegDst, WRegDataSrc, A1, A2,
    output RD1, RD2, WA, WD
  );
endinterface

// File: rtl/d_grf.sv
// d_grf: 32 x 32-bit general register file for the five-stage MIPS pipeline.
// Decodes the W-stage write-back fields into one write port, commits on the
// rising edge of Clk and serves two combinational read ports with W->D bypass.
// $0 is hard-wired to zero. Synchronous active-high Reset clears all registers.
// Optional feature macro: GRF_WRITE_LOG_EN prints one line per committed write.
module d_grf (
  input  logic    Clk,
  input  logic    Reset,
  d_grf_if.slave  bus
);

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_RA   = 2'd2,
    DST_NONE = 2'd3
  } dst_e;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_DM   = 2'd1,
    SRC_LINK = 2'd2,
    SRC_ZERO = 2'd3
  } src_e;

  // Storage for $1..$31; $0 has no storage and is decoded away on read.
  logic [31:0] regs_q [1:31];

  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  sel_addr;

  // Only the rt/rd fields of the instruction word matter here.
  logic unused_ins_bits;
  assign unused_ins_bits = ^{bus.WIns[31:21], bus.WIns[10:0]};

  // Write-port decode: destination address and data from the W-stage fields.
  always_comb begin
    sel_addr = '0;
    wr_data  = '0;
    case (dst_e'(bus.WRegDst))
      DST_RT:   sel_addr = bus.WIns[20:16];
      DST_RD:   sel_addr = bus.WIns[15:11];
      DST_RA:   sel_addr = 5'd31;
      DST_NONE: sel_addr = '0;
      default:  sel_addr = '0;
    endcase
    case (src_e'(bus.WRegDataSrc))
      SRC_ALU:  wr_data = bus.WALU;
      SRC_DM:   wr_data = bus.WDM;
      SRC_LINK: wr_data = bus.WPC + 32'd8;
      SRC_ZERO: wr_data = '0;
      default:  wr_data = '0;
    endcase
    wr_addr = (bus.WRegWrite && (dst_e'(bus.WRegDst) != DST_NONE)) ? sel_addr : '0;
  end

  assign bus.WA = wr_addr;
  assign bus.WD = wr_data;

  // Commit: Reset clears everything and wins over a same-cycle write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs_q <= '{default: '0};
    end else if (wr_addr != '0) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read ports: $0 reads zero, a live W write to the same address bypasses storage.
  always_comb begin
    bus.RD1 = '0;
    bus.RD2 = '0;
    if (bus.A1 != '0) begin
      bus.RD1 = (bus.A1 == wr_addr) ? wr_data : regs_q[bus.A1];
    end
    if (bus.A2 != '0) begin
      bus.RD2 = (bus.A2 == wr_addr) ? wr_data : regs_q[bus.A2];
    end
  end

`ifdef GRF_WRITE_LOG_EN
  // Judge-format write log, one line per committed write.
  always_ff @(posedge Clk) begin
    if (!Reset && (wr_addr != '0)) begin
      $display("%d@%h: $%d <= %h", $time, bus.WPC, wr_addr, wr_data);
    end
  end
`else
  // No write log in this build.
`endif

endmodule

// File: tb/tb_d_grf.sv
// tb_d_grf: self-checking bench for d_grf. Hand-written vector table for the
// directed cases, a reset-priority sequence, then randomized cycles checked
// against an array-based reference model of the register file.
module tb_d_grf;

  logic Clk = 1'b0;
  logic Reset;
  int unsigned errors = 0;
  int unsigned checks = 0;

  d_grf_if bus ();

  d_grf dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  dst;
    logic [1:0]  src;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
  } vec_t;

  vec_t tbl [13];
  logic [31:0] mem [32];

  function automatic logic [31:0] mk(input int rt, input int rd);
    return (32'(rt) << 16) | (32'(rd) << 11);
  endfunction

  // Reference write address from the architectural rules.
  function automatic logic [31:0] m_wa(input logic we, input logic [1:0] dst, input logic [31:0] ins);
    if (!we) return 0;
    case (dst)
      2'd0: return (ins >> 16) % 32;
      2'd1: return (ins >> 11) % 32;
      2'd2: return 31;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] src, input logic [31:0] pc,
                                       input logic [31:0] alu, input logic [31:0] dm);
    longint unsigned link;
    link = (longint'(pc) + 8) % 64'h1_0000_0000;
    case (src)
      2'd0: return alu;
      2'd1: return dm;
      2'd2: return link[31:0];
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a, input logic [31:0] wa, input logic [31:0] wd);
    if (a == 0) return 0;
    if (32'(a) == wa) return wd;
    return mem[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [1:0] dst, input logic [1:0] src,
                       input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [4:0] a1, input logic [4:0] a2);
    Reset           = rst;
    bus.WRegWrite   = we;
    bus.WRegDst     = dst;
    bus.WRegDataSrc = src;
    bus.WIns        = ins;
    bus.WPC         = pc;
    bus.WALU        = alu;
    bus.WDM         = dm;
    bus.A1          = a1;
    bus.A2          = a2;
  endtask

  // Advance to just after the next edge, then drive.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'd0, 2'd0, '0, '0, '0, '0, 5'd0, 5'd0);
    step();
    step();
    Reset = 1'b0;
    foreach (mem[i]) mem[i] = 0;

    // All addresses read zero after reset.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 2'd0, 2'd0, '0, '0, '0, '0, 5'(i), 5'(i + 16));
      #2;
      chk($sformatf("rst_rd1[%0d]", i), bus.RD1, 32'h0);
      chk($sformatf("rst_rd2[%0d]", i + 16), bus.RD2, 32'h0);
      step();
    end

    //          rst   we   dst   src  ins         pc            alu           dm            a1 a2  wa  wd            rd1           rd2
    tbl[0]  = '{1'b0, 1'b1, 2'd1, 2'd0, mk(0, 8),  32'h0000_3000, 32'h1234_5678, 32'h0,       8, 0,  8, 32'h1234_5678, 32'h1234_5678, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 2'd1, 2'd0, mk(0, 8),  32'h0000_3004, 32'h0,         32'h0,       8, 8,  0, 32'h0,         32'h1234_5678, 32'h1234_5678};
    tbl[2]  = '{1'b0, 1'b1, 2'd2, 2'd2, 32'h0,     32'h0000_3010, 32'h0,         32'h0,      31, 8, 31, 32'h0000_3018, 32'h0000_3018, 32'h1234_5678};
    tbl[3]  = '{1'b0, 1'b1, 2'd2, 2'd2, 32'h0,     32'hFFFF_FFFC, 32'h0,         32'h0,      31, 0, 31, 32'h0000_0004, 32'h0000_0004, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 2'd3, 32'h0,     32'h0,         32'h0,         32'h0,      31, 0,  0, 32'h0,         32'h0000_0004, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 2'd0, mk(0, 0),  32'h0,         32'hDEAD_BEEF, 32'h0,       0, 31, 0, 32'hDEAD_BEEF, 32'h0,         32'h0000_0004};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 2'd0, mk(9, 0),  32'h0,         32'h0000_9999, 32'h0,       9, 0,  9, 32'h0000_9999, 32'h0000_9999, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 2'd3, 2'd0, mk(9, 0),  32'h0,         32'h1111_1111, 32'h0,       0, 9,  0, 32'h1111_1111, 32'h0,         32'h0000_9999};
    tbl[8]  = '{1'b0, 1'b1, 2'd1, 2'd1, mk(0, 10), 32'h0,         32'h0,         32'hCAFE_F00D, 10, 10, 10, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};
    tbl[9]  = '{1'b0, 1'b0, 2'd1, 2'd0, 32'h0,     32'h0,         32'h0,         32'h0,      10, 9,  0, 32'h0,         32'hCAFE_F00D, 32'h0000_9999};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 2'd0, mk(0, 12), 32'h0,         32'h0000_0001, 32'h0,      12, 0, 12, 32'h0000_0001, 32'h0000_0001, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 2'd1, 2'd0, mk(0, 12), 32'h0,         32'h0000_0002, 32'h0,      12, 12, 12, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002};
    tbl[12] = '{1'b0, 1'b0, 2'd1, 2'd0, mk(0, 12), 32'h0,         32'h0,         32'h0,      12, 8,  0, 32'h0,         32'h0000_0002, 32'h1234_5678};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].dst, tbl[i].src, tbl[i].ins, tbl[i].pc,
            tbl[i].alu, tbl[i].dm, tbl[i].a1, tbl[i].a2);
      #2;
      chk($sformatf("tbl%0d_wa", i), 32'(bus.WA), tbl[i].e_wa);
      chk($sformatf("tbl%0d_wd", i), bus.WD, tbl[i].e_wd);
      chk($sformatf("tbl%0d_rd1", i), bus.RD1, tbl[i].e_rd1);
      chk($sformatf("tbl%0d_rd2", i), bus.RD2, tbl[i].e_rd2);
      step();
    end

    // Reset beats a same-cycle write; bypass stays visible during the reset cycle.
    drive(1'b0, 1'b1, 2'd1, 2'd0, mk(0, 5), 32'h0, 32'hAAAA_AAAA, 32'h0, 5, 0);
    #2;
    chk("seq_w5", bus.RD1, 32'hAAAA_AAAA);
    step();
    drive(1'b1, 1'b1, 2'd1, 2'd0, mk(0, 5), 32'h0, 32'h5555_5555, 32'h0, 5, 12);
    #2;
    chk("seq_rst_byp", bus.RD1, 32'h5555_5555);
    step();
    drive(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5, 12);
    #2;
    chk("seq_after_rst5", bus.RD1, 32'h0);
    chk("seq_after_rst12", bus.RD2, 32'h0);
    bus.A1 = 31;
    bus.A2 = 10;
    #1;
    chk("seq_after_rst31", bus.RD1, 32'h0);
    chk("seq_after_rst10", bus.RD2, 32'h0);
    step();
    foreach (mem[i]) mem[i] = 0;

    // Randomized cycles against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic        rst;
      logic [1:0]  dst;
      logic [1:0]  src;
      logic [31:0] ins, pc, wa, wd;
      logic [4:0]  a1, a2;
      rst = ($urandom_range(0, 49) == 0);
      dst = 2'($urandom_range(0, 3));
      src = 2'($urandom_range(0, 3));
      ins = $urandom;
      pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      a1  = 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? ins[15:11] : 5'($urandom_range(0, 31));
      drive(rst, 1'($urandom_range(0, 3) != 0), dst, src, ins, pc, $urandom, $urandom, a1, a2);
      wa = m_wa(bus.WRegWrite, dst, ins);
      wd = m_wd(src, pc, bus.WALU, bus.WDM);
      #2;
      chk($sformatf("rnd%0d_wa", n), 32'(bus.WA), wa);
      chk($sformatf("rnd%0d_wd", n), bus.WD, wd);
      chk($sformatf("rnd%0d_rd1", n), bus.RD1, m_rd(a1, wa, wd));
      chk($sformatf("rnd%0d_rd2", n), bus.RD2, m_rd(a2, wa, wd));
      if (rst) foreach (mem[i]) mem[i] = 0;
      else if (wa != 0) mem[wa] = wd;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
